// File: rtl/bcd_scan_counter_if.sv
// Control/display bundle for bcd_scan_counter.
// master drives count controls, slave drives display outputs.
interface bcd_scan_counter_if;
  logic       en;
  logic       up;
  logic       clear;
  logic [3:0] bcd;
  logic [3:0] an;
  logic       wrap;

  modport master (
    output en, up, clear,
    input  bcd, an, wrap
  );

  modport slave (
    input  en, up, clear,
    output bcd, an, wrap
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with display scan mux.
// Optional leading-zero blanking: BCD_SCAN_LEADING_ZERO_BLANK_EN.
module bcd_scan_counter #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input logic           clk,
  input logic           rst_n,
  bcd_scan_counter_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } sel_e;

  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  sel_e            sel_q, sel_d;
  logic [3:0][3:0] d_q, d_d;
  logic            wrap_q, wrap_d;
  logic            tick;
  logic            cy;

  assign tick = bus.en && (pcnt_q == P_MAX);

  always_comb begin
    pcnt_d = pcnt_q;
    d_d    = d_q;
    wrap_d = 1'b0;
    cy     = 1'b1;
    if (bus.clear) begin
      pcnt_d = '0;
      d_d    = '0;
    end else begin
      if (bus.en)
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      if (tick) begin
        // ripple carry/borrow; cy survives only if every digit rolled
        for (int i = 0; i < 4; i++) begin
          if (cy) begin
            if (bus.up) begin
              if (d_q[i] == 4'd9) d_d[i] = 4'd0;
              else begin
                d_d[i] = d_q[i] + 4'd1;
                cy     = 1'b0;
              end
            end else begin
              if (d_q[i] == 4'd0) d_d[i] = 4'd9;
              else begin
                d_d[i] = d_q[i] - 4'd1;
                cy     = 1'b0;
              end
            end
          end
        end
        wrap_d = cy;
      end
    end
  end

  always_comb begin
    scnt_d = scnt_q + 1'b1;
    sel_d  = sel_q;
    if (scnt_q == S_MAX) begin
      scnt_d = '0;
      unique case (sel_q)
        S0: sel_d = S1;
        S1: sel_d = S2;
        S2: sel_d = S3;
        S3: sel_d = S0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      scnt_q <= '0;
      sel_q  <= S0;
      d_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      scnt_q <= scnt_d;
      sel_q  <= sel_d;
      d_q    <= d_d;
      wrap_q <= wrap_d;
    end
  end

  logic [3:0] bcd_o;

  always_comb begin
    bcd_o = d_q[sel_q];
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    unique case (sel_q)
      S1: if (d_q[3] == 0 && d_q[2] == 0 && d_q[1] == 0)
            bcd_o = 4'hF;
      S2: if (d_q[3] == 0 && d_q[2] == 0)
            bcd_o = 4'hF;
      S3: if (d_q[3] == 0)
            bcd_o = 4'hF;
      default: ;
    endcase
`endif
  end

  assign bus.bcd  = bcd_o;
  assign bus.an   = ~(4'b0001 << sel_q);
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomized bench for bcd_scan_counter against an
// integer-count reference model.
module tb_bcd_scan_counter;

  localparam int TD = 2;
  localparam int SD = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  bcd_scan_counter_if bus ();

  bcd_scan_counter #(
    .TICK_DIV (TD),
    .SCAN_DIV (SD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference state: count as an integer 0..9999
  int m_cnt;
  int m_p;
  int m_s;
  int m_sel;
  bit m_wrap;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [3:0] exp_an(input int s);
    case (s)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [3:0] exp_bcd(input int c, input int s);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    if (s > 0 && c < pow10(s)) return 4'hF;
`endif
    return 4'((c / pow10(s)) % 10);
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_p    = 0;
    m_s    = 0;
    m_sel  = 0;
    m_wrap = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".an"},   32'(bus.an),   32'(exp_an(m_sel)));
    chk({tag, ".bcd"},  32'(bus.bcd),  32'(exp_bcd(m_cnt, m_sel)));
    chk({tag, ".wrap"}, 32'(bus.wrap), 32'(m_wrap));
  endtask

  // called at a negedge: check, drive inputs, advance model
  task automatic step(input string tag, input bit e,
                      input bit u, input bit c);
    bit tk;
    check_outs(tag);
    bus.en    = e;
    bus.up    = u;
    bus.clear = c;
    tk = e && (m_p == TD - 1);
    m_wrap = 0;
    if (c) begin
      m_cnt = 0;
      m_p   = 0;
    end else begin
      if (e) m_p = tk ? 0 : m_p + 1;
      if (tk) begin
        if (u) begin
          m_wrap = (m_cnt == 9999);
          m_cnt  = (m_cnt + 1) % 10000;
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + 9999) % 10000;
        end
      end
    end
    m_s = m_s + 1;
    if (m_s == SD) begin
      m_s   = 0;
      m_sel = (m_sel + 1) % 4;
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.an",   32'(bus.an),   32'h0000000E);
    chk("rst.bcd",  32'(bus.bcd),  32'h0);
    chk("rst.wrap", 32'(bus.wrap), 32'h0);
    @(negedge clk);
    check_outs("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.up    = 1'b1;
    bus.clear = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst0.an",   32'(bus.an),   32'h0000000E);
    chk("rst0.bcd",  32'(bus.bcd),  32'h0);
    chk("rst0.wrap", 32'(bus.wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) step("hold", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++)  step("up", 1'b1, 1'b1, 1'b0);
    chk("up40.cnt", 32'(m_cnt), 32'd20);

    // count down through 0000 -> 9999 and back
    for (int i = 0; i < 60; i++)  step("down", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++)  step("upb", 1'b1, 1'b1, 1'b0);

    // climb into the hundreds for blanking coverage
    for (int i = 0; i < 900; i++) step("climb", 1'b1, 1'b1, 1'b0);
    step("clr", 1'b1, 1'b1, 1'b1);
    chk("clr.cnt", 32'(m_cnt), 32'd0);

    for (int i = 0; i < 6000; i++) begin
      bit e, u, c;
      e = ($urandom_range(0, 7) != 0);
      u = ($urandom_range(0, 1) != 0);
      c = ($urandom_range(0, 31) == 0);
      step("rnd", e, u, c);
      if ($urandom_range(0, 999) == 0) async_reset();
    end

    async_reset();
    for (int i = 0; i < 30; i++) step("post", 1'b1, 1'b0, 1'b0);
    check_outs("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
